// File: rtl/alu_mul_seq_pkg.sv
// rtl/alu_mul_seq_pkg.sv - shared types and Hack ALU control words for the sequential multiplier
package alu_mul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DBL  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_t;

  // Bit order zx nx zy ny f no
  localparam logic [5:0] ALU_OP_ZERO = 6'b101010;
  localparam logic [5:0] ALU_OP_ADD  = 6'b000010;

  function automatic logic state_busy(input mul_state_t s);
    return (s == ST_ADD) || (s == ST_DBL);
  endfunction

endpackage

// File: rtl/alu_mul_fsm.sv
// rtl/alu_mul_fsm.sv - multiplier sequencer: state register, next-state and ALU control decode
module alu_mul_fsm
  import alu_mul_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  input  logic [W-1:0] req_b,
  input  logic [W-1:0] b_shr,
  input  logic         res_ready,
  output mul_state_t   state,
  output logic         req_ready,
  output logic         res_valid,
  output logic [5:0]   alu_ctrl
);

  mul_state_t state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // b_shr is the multiplier after the pending shift; its LSB picks the next step
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_b == '0)   state_d = ST_DONE;
          else if (req_b[0]) state_d = ST_ADD;
          else               state_d = ST_DBL;
        end
      end
      ST_ADD:  state_d = (b_shr == '0) ? ST_DONE : ST_DBL;
      ST_DBL:  state_d = b_shr[0] ? ST_ADD : ST_DBL;
      ST_DONE: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = (state == ST_IDLE);
  assign res_valid = (state == ST_DONE);
  assign alu_ctrl  = state_busy(state) ? ALU_OP_ADD : ALU_OP_ZERO;

endmodule

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-and-add 16-bit multiplier driving an external Hack ALU
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_p,
  output logic [W-1:0] alu_x,
  output logic [W-1:0] alu_y,
  output logic         alu_zx,
  output logic         alu_nx,
  output logic         alu_zy,
  output logic         alu_ny,
  output logic         alu_f,
  output logic         alu_no,
  input  logic [W-1:0] alu_out,
  input  logic         alu_zr,
  input  logic         alu_ng
);

  mul_state_t   state;
  logic [5:0]   alu_ctrl;
  logic [W-1:0] acc, a, b;
  logic [W-1:0] b_shr;
  logic         unused_flags;

  assign b_shr        = b >> 1;
  assign unused_flags = alu_zr ^ alu_ng;

  alu_mul_fsm #(.W(W)) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_b     (req_b),
    .b_shr     (b_shr),
    .res_ready (res_ready),
    .state     (state),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .alu_ctrl  (alu_ctrl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      a   <= '0;
      b   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            acc <= '0;
            a   <= req_a;
            b   <= req_b;
          end
        end
        ST_ADD: acc <= alu_out;
        ST_DBL: begin
          a <= alu_out;
          b <= b_shr;
        end
        default: ;
      endcase
    end
  end

  // Operands follow registered state only, so no path exists from req_* to the ALU
  always_comb begin
    alu_x = '0;
    alu_y = '0;
    case (state)
      ST_ADD: begin
        alu_x = acc;
        alu_y = a;
      end
      ST_DBL: begin
        alu_x = a;
        alu_y = a;
      end
      default: ;
    endcase
  end

  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = alu_ctrl;
  assign res_p = acc;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - self-checking bench for alu_mul_seq with a behavioural Hack ALU
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_p;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic        alu_zr, alu_ng;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_p     (res_p),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_zx    (alu_zx),
    .alu_nx    (alu_nx),
    .alu_zy    (alu_zy),
    .alu_ny    (alu_ny),
    .alu_f     (alu_f),
    .alu_no    (alu_no),
    .alu_out   (alu_out),
    .alu_zr    (alu_zr),
    .alu_ng    (alu_ng)
  );

  // Hack ALU
  logic [15:0] hx1, hx2, hy1, hy2, ho;
  always_comb begin
    hx1 = alu_zx ? 16'h0000 : alu_x;
    hx2 = alu_nx ? ~hx1 : hx1;
    hy1 = alu_zy ? 16'h0000 : alu_y;
    hy2 = alu_ny ? ~hy1 : hy1;
    ho  = alu_f ? (hx2 + hy2) : (hx2 & hy2);
    alu_out = alu_no ? ~ho : ho;
    alu_zr  = (alu_out == 16'h0000);
    alu_ng  = alu_out[15];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_prod(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] full;
    full = x * y;
    return full[15:0];
  endfunction

  function automatic int exp_k(input logic [15:0] y);
    int pc, msb;
    pc = 0;
    msb = 0;
    for (int i = 0; i < 16; i++) begin
      if (y[i]) begin
        pc++;
        msb = i;
      end
    end
    return pc + msb;
  endfunction

  // Model: 0 idle, 1 computing for m_left more edges, 2 holding product
  int          m_phase = 0;
  int          m_left = 0;
  logic [15:0] m_p = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_left  = 0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
          m_p    = exp_prod(req_a, req_b);
          m_left = exp_k(req_b);
          m_phase = (m_left == 0) ? 2 : 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (res_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mdl_req_ready", {31'd0, req_ready}, {31'd0, m_phase == 0});
      chk("mdl_res_valid", {31'd0, res_valid}, {31'd0, m_phase == 2});
      if (m_phase == 2) chk("mdl_res_p", {16'd0, res_p}, {16'd0, m_p});
      if (m_phase == 1) begin
        chk("mdl_ctrl_add", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'h02);
      end else begin
        chk("mdl_ctrl_zero", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'h2A);
        chk("mdl_xy_zero", {alu_x, alu_y}, 32'h0);
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] p,
                        input int k, input int stall, input bit pulse);
    int cnt;
    chk("pre_req_ready", {31'd0, req_ready}, 32'd1);
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cnt = 0;
    while (!res_valid && cnt < 64) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("latency_k", cnt, k);
    chk("res_p", {16'd0, res_p}, {16'd0, p});
    for (int i = 0; i < stall; i++) begin
      if (pulse) begin
        req_valid = i[0];
        req_a = 16'h5555;
        req_b = 16'h0003;
      end
      @(posedge clk);
      #1;
      if (pulse) begin
        chk("hold_valid", {31'd0, res_valid}, 32'd1);
        chk("hold_p", {16'd0, res_p}, {16'd0, p});
        chk("hold_ready", {31'd0, req_ready}, 32'd0);
      end
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("post_valid_low", {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_p", {16'd0, res_p}, 32'd0);
    chk("rst_ctrl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'h2A);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    run_op(16'h0003, 16'h0005, 16'h000F, 4, 0, 1'b0);
    run_op(16'h1234, 16'h0000, 16'h0000, 0, 1, 1'b0);
    run_op(16'h1234, 16'h0001, 16'h1234, 1, 0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 16'h0001, 31, 0, 1'b0);
    run_op(16'h8000, 16'h0002, 16'h0000, 2, 0, 1'b0);
    run_op(16'h0011, 16'h0003, 16'h0033, 3, 10, 1'b1);

    // Abort in the middle of a DBL step
    req_a = 16'h7FFF;
    req_b = 16'h00FF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_res_valid", {31'd0, res_valid}, 32'd0);
    chk("abort_res_p", {16'd0, res_p}, 32'd0);
    chk("abort_ctrl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'h2A);
    chk("abort_xy", {alu_x, alu_y}, 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_no_result", {31'd0, res_valid}, 32'd0);
    run_op(16'h0007, 16'h0006, 16'h002A, 4, 0, 1'b0);

    for (int n = 0; n < 2000; n++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 4 == 0) rb = rb >> $urandom_range(8, 15);
      run_op(ra, rb, exp_prod(ra, rb), exp_k(rb), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
